// File: rtl/key_event_queue_if.sv
// Keycode/vsync inputs and presented-event outputs of the key event queue.
interface key_event_queue_if #(
   parameter int unsigned FIFO_DEPTH = 4
);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [7:0]       keycode_in;
   logic             vs;
   logic [7:0]       key_out;
   logic             key_valid;
   logic [CNT_W-1:0] fifo_count;
   logic             overflow;

   modport master (
      output keycode_in, vs,
      input  key_out, key_valid, fifo_count, overflow
   );

   modport slave (
      input  keycode_in, vs,
      output key_out, key_valid, fifo_count, overflow
   );
endinterface

// File: rtl/key_event_queue.sv
// Synchronises, filters and debounces game keycodes, queues one event per press
// and presents queued events to the game block one vsync frame at a time.
module key_event_queue #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned FIFO_DEPTH      = 4,
   parameter int unsigned HOLD_FRAMES     = 1
) (
   input logic              pixel_clk,
   input logic              Reset_n,
   key_event_queue_if.slave bus
);
   localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

   localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);

   typedef enum logic {ST_IDLE, ST_PRESENT} state_e;

   logic [7:0]        kc_s1_q, kc_s2_q;
   logic              vs_s1_q, vs_s2_q, vs_s3_q;
   logic [7:0]        cand_q, cand_d;
   logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
   logic [7:0]        stable_q, stable_d;
   logic [7:0]        mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ovf_q, ovf_d;
   state_e            state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [7:0]        key_out_q, key_out_d;
   logic              key_valid_q, key_valid_d;

   logic [7:0] filt_c;
   logic [7:0] head_c;
   logic       vs_rise_c, push_c, pop_c, wr_en_c, empty_c, full_c;

   // Only the five game keys survive; anything else reads as a release.
   always_comb begin
      filt_c = 8'h00;
      case (kc_s2_q)
         8'h07, 8'h09, 8'h2C, 8'h0D, 8'h0E: filt_c = kc_s2_q;
         default:                           filt_c = 8'h00;
      endcase
   end

   always_comb begin
      cand_d   = cand_q;
      db_cnt_d = db_cnt_q;
      stable_d = stable_q;
      if (filt_c != cand_q) begin
         cand_d   = filt_c;
         db_cnt_d = '0;
      end else begin
         if (db_cnt_q != DB_MAX) db_cnt_d = db_cnt_q + DB_W'(1);
         if (db_cnt_q == DB_MAX) stable_d = cand_q;
      end
   end

   // A press is a change of the stable code to a new nonzero key.
   assign push_c    = (stable_d != stable_q) && (stable_d != 8'h00);
   assign vs_rise_c = vs_s2_q && !vs_s3_q;
   assign empty_c   = (count_q == '0);
   assign full_c    = (count_q == CNT_FULL);
   assign wr_en_c   = push_c && (!full_c || pop_c);
   assign head_c    = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      if (wr_en_c && !pop_c)      count_d = count_q + CNT_W'(1);
      else if (!wr_en_c && pop_c) count_d = count_q - CNT_W'(1);
      ovf_d = ovf_q || (push_c && full_c && !pop_c);
   end

   // Presenter: next-state and registered output values.
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      key_out_d   = key_out_q;
      key_valid_d = key_valid_q;
      pop_c       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (vs_rise_c && !empty_c) begin
               pop_c       = 1'b1;
               key_out_d   = head_c;
               key_valid_d = 1'b1;
               hold_d      = HOLD_INIT;
               state_d     = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            if (vs_rise_c) begin
               if (hold_q > HOLD_W'(1)) begin
                  hold_d = hold_q - HOLD_W'(1);
               end else if (!empty_c) begin
                  pop_c     = 1'b1;
                  key_out_d = head_c;
                  hold_d    = HOLD_INIT;
               end else begin
                  key_out_d   = 8'h00;
                  key_valid_d = 1'b0;
                  hold_d      = '0;
                  state_d     = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge pixel_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         kc_s1_q  <= 8'h00;
         kc_s2_q  <= 8'h00;
         vs_s1_q  <= 1'b0;
         vs_s2_q  <= 1'b0;
         vs_s3_q  <= 1'b0;
         cand_q   <= 8'h00;
         db_cnt_q <= '0;
         stable_q <= 8'h00;
      end else begin
         kc_s1_q  <= bus.keycode_in;
         kc_s2_q  <= kc_s1_q;
         vs_s1_q  <= bus.vs;
         vs_s2_q  <= vs_s1_q;
         vs_s3_q  <= vs_s2_q;
         cand_q   <= cand_d;
         db_cnt_q <= db_cnt_d;
         stable_q <= stable_d;
      end
   end

   always_ff @(posedge pixel_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (wr_en_c) begin
            mem_q[wr_ptr_q] <= stable_d;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge pixel_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= ST_IDLE;
         hold_q      <= '0;
         key_out_q   <= 8'h00;
         key_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         key_out_q   <= key_out_d;
         key_valid_q <= key_valid_d;
      end
   end

   assign bus.key_out    = key_out_q;
   assign bus.key_valid  = key_valid_q;
   assign bus.fifo_count = count_q;
   assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: directed scenarios plus random key sequences
// compared against an event-level model of press detection and queueing.
module tb_key_event_queue;
   localparam int DC = 4;
   localparam int FD = 4;
   localparam int HF = 1;

   logic pixel_clk = 1'b0;
   logic Reset_n   = 1'b0;

   key_event_queue_if #(.FIFO_DEPTH(FD)) bus ();

   key_event_queue #(
      .DEBOUNCE_CYCLES(DC),
      .FIFO_DEPTH     (FD),
      .HOLD_FRAMES    (HF)
   ) dut (
      .pixel_clk(pixel_clk),
      .Reset_n  (Reset_n),
      .bus      (bus)
   );

   always #5 pixel_clk = ~pixel_clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: queued events, last accepted key, current run of one filtered code.
   logic [7:0] mq [$];
   logic [7:0] m_stable;
   logic [7:0] run_f;
   int         run_len;
   logic       m_ovf;
   logic [7:0] exp_out;
   logic       exp_valid;

   logic [7:0] keys [5] = '{8'h07, 8'h09, 8'h2C, 8'h0D, 8'h0E};

   function automatic logic [7:0] filt(input logic [7:0] c);
      return (c inside {8'h07, 8'h09, 8'h2C, 8'h0D, 8'h0E}) ? c : 8'h00;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge pixel_clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".key_out"},    32'(bus.key_out),    32'(exp_out));
      check({tag, ".key_valid"},  32'(bus.key_valid),  32'(exp_valid));
      check({tag, ".fifo_count"}, 32'(bus.fifo_count), 32'(mq.size()));
      check({tag, ".overflow"},   32'(bus.overflow),   32'(m_ovf));
   endtask

   task automatic model_reset();
      mq.delete();
      m_stable  = 8'h00;
      run_f     = 8'h00;
      run_len   = 1000;
      m_ovf     = 1'b0;
      exp_out   = 8'h00;
      exp_valid = 1'b0;
   endtask

   task automatic model_push(input logic [7:0] k);
      if (mq.size() < FD) mq.push_back(k);
      else m_ovf = 1'b1;
   endtask

   // Hold a raw keycode for len cycles; a filtered run longer than DC is accepted.
   task automatic seg(input logic [7:0] raw, input int len);
      logic [7:0] f;
      f = filt(raw);
      bus.keycode_in = raw;
      if (f == run_f) run_len += len;
      else begin
         run_f   = f;
         run_len = len;
      end
      if (run_len >= DC + 1 && run_f != m_stable) begin
         if (run_f != 8'h00) model_push(run_f);
         m_stable = run_f;
      end
      tick(len);
   endtask

   // One 100-cycle vsync frame; each frame shows the next queued event or nothing.
   task automatic vs_pulse(input string tag);
      bus.vs = 1'b1;
      tick(4);
      if (mq.size() > 0) begin
         exp_out   = mq.pop_front();
         exp_valid = 1'b1;
      end else begin
         exp_out   = 8'h00;
         exp_valid = 1'b0;
      end
      check_all(tag);
      tick(6);
      bus.vs = 1'b0;
      tick(90);
   endtask

   task automatic do_reset();
      bus.keycode_in = 8'h00;
      Reset_n = 1'b0;
      tick(2);
      Reset_n = 1'b1;
      tick(3);
      model_reset();
   endtask

   logic [7:0] f_r, raw_r, prev_f;
   int         len_r;

   initial begin
      bus.keycode_in = 8'h00;
      bus.vs         = 1'b0;
      model_reset();
      Reset_n = 1'b0;
      tick(3);
      check_all("reset");
      Reset_n = 1'b1;
      tick(5);

      // Basic press: push lands on the 7th edge after the change
      bus.keycode_in = 8'h07;
      tick(6);
      check("press_edge6.count", 32'(bus.fifo_count), 32'd0);
      tick(1);
      check("press_edge7.count", 32'(bus.fifo_count), 32'd1);
      mq.push_back(8'h07);
      m_stable = 8'h07;
      run_f    = 8'h07;
      run_len  = 50;
      tick(43);
      seg(8'h00, 50);
      bus.vs = 1'b1;
      tick(2);
      check("vs_edge2.key_valid", 32'(bus.key_valid), 32'd0);
      tick(1);
      exp_out   = mq.pop_front();
      exp_valid = 1'b1;
      check_all("vs_edge3");
      tick(7);
      bus.vs = 1'b0;
      tick(90);
      vs_pulse("basic_clear");

      // Filter and glitch
      seg(8'h04, 50);
      check_all("filter_04");
      seg(8'h0E, 2);
      seg(8'h00, 50);
      check_all("glitch_0E");

      // Key change while held, no release in between
      seg(8'h09, 300);
      seg(8'h0D, 300);
      seg(8'h00, 50);
      check_all("keychange_queued");
      vs_pulse("keychange_f1");
      vs_pulse("keychange_f2");
      vs_pulse("keychange_f3");

      // Overflow with vs held low
      foreach (keys[i]) begin
         seg(keys[i], 20);
         seg(8'h00, 20);
      end
      seg(8'h07, 20);
      seg(8'h00, 20);
      check_all("overflow_full");
      for (int p = 0; p < 5; p++) vs_pulse("overflow_drain");

      // Push aligned with the vs_rise pop on a full queue
      do_reset();
      for (int i = 0; i < 4; i++) begin
         seg(keys[i], 20);
         seg(8'h00, 20);
      end
      check_all("simul_full");
      bus.keycode_in = 8'h0E;
      tick(4);
      bus.vs = 1'b1;
      tick(2);
      check("simul_pre.count", 32'(bus.fifo_count), 32'd4);
      tick(1);
      exp_out   = mq.pop_front();
      exp_valid = 1'b1;
      mq.push_back(8'h0E);
      m_stable = 8'h0E;
      run_f    = 8'h0E;
      run_len  = 1000;
      check_all("simul_edge");
      tick(5);
      bus.vs = 1'b0;
      tick(90);
      seg(8'h00, 30);
      for (int p = 0; p < 5; p++) vs_pulse("simul_drain");

      // Asynchronous reset during a presentation
      seg(8'h2C, 20); seg(8'h00, 20);
      seg(8'h0D, 20); seg(8'h00, 20);
      seg(8'h0E, 20); seg(8'h00, 20);
      vs_pulse("rst_pre");
      @(negedge pixel_clk);
      #3 Reset_n = 1'b0;
      #1;
      model_reset();
      check_all("rst_async");
      @(negedge pixel_clk);
      Reset_n = 1'b1;
      tick(50);
      check_all("rst_after");
      vs_pulse("rst_no_event");
      seg(8'h09, 20);
      seg(8'h00, 20);
      check_all("rst_fresh");
      vs_pulse("rst_fresh_show");

      // Random key sequences
      for (int r = 0; r < 2; r++) begin
         do_reset();
         prev_f = 8'h00;
         for (int s = 0; s < 40; s++) begin
            do begin
               if ($urandom_range(0, 2) == 0) f_r = 8'h00;
               else f_r = keys[$urandom_range(0, 4)];
            end while (f_r == prev_f);
            raw_r = f_r;
            if (f_r == 8'h00) begin
               do raw_r = 8'($urandom_range(0, 255)); while (filt(raw_r) != 8'h00);
            end
            if ($urandom_range(0, 1) == 0) len_r = int'($urandom_range(1, DC - 1));
            else len_r = int'($urandom_range(DC + 2, 40));
            seg(raw_r, len_r);
            prev_f = f_r;
         end
         seg(8'h00, 20);
         check_all("rand_fill");
         for (int p = 0; p <= FD; p++) vs_pulse("rand_drain");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
